// File: rtl/hough_pkg.sv
// Shared Hough constants: rho format, theta-index width and the Q1.6 cos/sin tables.
// The accumulator side imports the same definitions so both ends agree on theta and rho.
package hough_pkg;

    localparam int RHO_W  = 10;
    localparam int Q_FRAC = 6;

    // round(64*cos(m*2.8125 deg)) for m = 0..32, listed from m=32 down to m=0
    localparam logic [32:0][6:0] QCOS = {
        7'd0,  7'd3,  7'd6,  7'd9,  7'd12, 7'd16, 7'd19, 7'd22, 7'd24, 7'd27, 7'd30,
        7'd33, 7'd36, 7'd38, 7'd41, 7'd43, 7'd45, 7'd47, 7'd49, 7'd51, 7'd53, 7'd55,
        7'd56, 7'd58, 7'd59, 7'd60, 7'd61, 7'd62, 7'd63, 7'd63, 7'd64, 7'd64, 7'd64
    };

    function automatic int theta_w(input int ntheta);
        return (ntheta <= 1) ? 1 : $clog2(ntheta);
    endfunction

    // Theta k maps onto the 64-step half-circle grid; cos is odd about 90 deg.
    function automatic logic signed [7:0] lut_cos(input int ntheta, input int k);
        int m;
        m = k * (64 / ntheta);
        if (m <= 32)
            return $signed({1'b0, QCOS[6'(m)]});
        return -$signed({1'b0, QCOS[6'(64 - m)]});
    endfunction

    function automatic logic signed [7:0] lut_sin(input int ntheta, input int k);
        int m;
        m = k * (64 / ntheta);
        if (m <= 32)
            return $signed({1'b0, QCOS[6'(32 - m)]});
        return $signed({1'b0, QCOS[6'(m - 32)]});
    endfunction

endpackage

// File: rtl/hough_vote_gen_if.sv
// Vote beat bus toward the accumulator RAM controller: valid/ready with theta, rho and frame marker.
interface hough_vote_gen_if #(
    parameter int NTHETA = 16
) ();
    localparam int TW = hough_pkg::theta_w(NTHETA);

    logic                                VoteValid;
    logic                                VoteReady;
    logic [TW-1:0]                       VoteTheta;
    logic signed [hough_pkg::RHO_W-1:0]  VoteRho;
    logic                                VoteFrame;

    modport master (output VoteValid, VoteTheta, VoteRho, VoteFrame, input VoteReady);
    modport slave  (input VoteValid, VoteTheta, VoteRho, VoteFrame, output VoteReady);
endinterface

// File: rtl/hough_point_fifo.sv
// Edge-point FIFO with a registered read port; a pop and a push may both succeed when full.
module hough_point_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         push_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         pop_i,
    output logic [W-1:0] rd_data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [W-1:0]  rd_data_q;
    logic          do_push, do_pop;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign rd_data_o = rd_data_q;

    always_ff @(posedge Clk) begin
        if (do_push)
            mem[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= mem[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/hough_vote_gen.sv
// Turns qualifying pixels into (theta, rho) Hough votes, one beat per cycle, followed by
// a single end-of-frame marker once every vote of the frame has left.
module hough_vote_gen
    import hough_pkg::*;
#(
    parameter int THRESH     = 128,
    parameter int NTHETA     = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    FrameIn,
    input  logic [7:0]              Data,
    input  logic [7:0]              I,
    input  logic [7:0]              J,
    hough_vote_gen_if.master        vote,
    output logic                    Overflow,
    output logic [7:0]              DropCount,
    output logic                    Busy
);
    localparam int TW = theta_w(NTHETA);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_MARK  = 2'd2;

    logic signed [7:0] cos_lut [NTHETA];
    logic signed [7:0] sin_lut [NTHETA];

    genvar gi;
    generate
        for (gi = 0; gi < NTHETA; gi++) begin : g_lut
            assign cos_lut[gi] = lut_cos(NTHETA, gi);
            assign sin_lut[gi] = lut_sin(NTHETA, gi);
        end
    endgenerate

    logic [1:0]             state_q, state_d;
    logic [TW-1:0]          theta_q, theta_d;
    logic                   pend_q, pend_d;
    logic                   frame_prev_q;
    logic                   valid_q, vframe_q;
    logic [TW-1:0]          vtheta_q;
    logic signed [RHO_W-1:0] rho_q, rho;
    logic                   overflow_q;
    logic [7:0]             drop_cnt_q;
    logic                   push, pop, drop, out_free, load_vote, load_mark;
    logic                   fifo_full, fifo_empty;
    logic [15:0]            point;
    logic signed [16:0]     sum;

    assign push = !FrameIn && (Data >= 8'(THRESH));
    assign drop = push && fifo_full && !pop;

    hough_point_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .push_i    (push),
        .wr_data_i ({I, J}),
        .pop_i     (pop),
        .rd_data_o (point),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // The FIFO read register doubles as the point registers for the sweep in progress.
    assign sum = $signed({9'd0, point[15:8]}) * 17'(cos_lut[theta_q])
               + $signed({9'd0, point[7:0]})  * 17'(sin_lut[theta_q]);
    assign rho = RHO_W'(sum >>> Q_FRAC);

    always_comb begin
        out_free  = !valid_q || vote.VoteReady;
        state_d   = state_q;
        theta_d   = theta_q;
        pop       = 1'b0;
        load_vote = 1'b0;
        load_mark = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    theta_d = '0;
                    state_d = S_SWEEP;
                end else if (pend_q && !valid_q) begin
                    state_d = S_MARK;
                end
            end
            S_SWEEP: begin
                if (out_free) begin
                    load_vote = 1'b1;
                    if (theta_q == TW'(NTHETA - 1)) begin
                        // Chain straight into the next queued point so there is no bubble.
                        theta_d = '0;
                        if (!fifo_empty) pop = 1'b1;
                        else             state_d = S_IDLE;
                    end else begin
                        theta_d = theta_q + TW'(1);
                    end
                end
            end
            S_MARK: begin
                if (out_free) begin
                    load_mark = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        pend_d = (pend_q && !load_mark) || (FrameIn && !frame_prev_q);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            theta_q      <= '0;
            pend_q       <= 1'b0;
            frame_prev_q <= 1'b0;
            valid_q      <= 1'b0;
            vtheta_q     <= '0;
            rho_q        <= '0;
            vframe_q     <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            theta_q      <= theta_d;
            pend_q       <= pend_d;
            frame_prev_q <= FrameIn;
            if (load_vote) begin
                valid_q  <= 1'b1;
                vtheta_q <= theta_q;
                rho_q    <= rho;
                vframe_q <= 1'b0;
            end else if (load_mark) begin
                valid_q  <= 1'b1;
                vtheta_q <= '0;
                rho_q    <= '0;
                vframe_q <= 1'b1;
            end else if (vote.VoteReady) begin
                valid_q  <= 1'b0;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF)
                    drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    assign vote.VoteValid = valid_q;
    assign vote.VoteTheta = vtheta_q;
    assign vote.VoteRho   = rho_q;
    assign vote.VoteFrame = vframe_q;
    assign Overflow       = overflow_q;
    assign DropCount      = drop_cnt_q;
    assign Busy           = !fifo_empty || (state_q != S_IDLE) || pend_q || valid_q;

endmodule

// File: tb/tb_hough_vote_gen.sv
// Directed bench for hough_vote_gen: a trigonometric reference model fills an expected-beat
// queue and one negedge process checks every accepted beat and every stalled hold.
module tb_hough_vote_gen;
    import hough_pkg::*;

    localparam int  NTHETA = 16;
    localparam real PI     = 3.14159265358979;

    typedef struct { int theta; int rho; bit frame; } beat_t;

    logic       Clk = 1'b0, Reset = 1'b1, FrameIn = 1'b0;
    logic [7:0] Data = 8'd0, I = 8'd0, J = 8'd0;
    logic       Overflow, Busy;
    logic [7:0] DropCount;
    logic       ready_drv = 1'b1;
    bit         rand_mode = 1'b0, ready_level = 1'b1;

    beat_t exp_q[$];
    beat_t log_q[$];
    int    checks = 0, failures = 0;

    hough_vote_gen_if #(.NTHETA(NTHETA)) vif ();
    assign vif.VoteReady = ready_drv;

    hough_vote_gen #(.THRESH(128), .NTHETA(NTHETA), .FIFO_DEPTH(16)) dut (
        .Clk(Clk), .Reset(Reset), .FrameIn(FrameIn), .Data(Data), .I(I), .J(J),
        .vote(vif), .Overflow(Overflow), .DropCount(DropCount), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        #2;
        ready_drv = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
    end

    initial begin
        #300000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s act=%0d req=%0d", name, act, req);
        end
    endtask

    // Reference model: rounded Q1.6 trig values and floor division by 64.
    function automatic int q6(input real x);
        return $rtoi($floor(x + 0.5));
    endfunction
    function automatic int mcos(input int k);
        return q6(64.0 * $cos(k * PI / NTHETA));
    endfunction
    function automatic int msin(input int k);
        return q6(64.0 * $sin(k * PI / NTHETA));
    endfunction
    function automatic int floordiv64(input int s);
        return (s >= 0) ? s / 64 : -((-s + 63) / 64);
    endfunction
    function automatic int model_rho(input int i, input int j, input int k);
        return floordiv64(i * mcos(k) + j * msin(k));
    endfunction

    task automatic expect_point(input int i, input int j);
        for (int k = 0; k < NTHETA; k++)
            exp_q.push_back('{k, model_rho(i, j, k), 1'b0});
    endtask

    task automatic send_px(input int i, input int j, input int d, input bit fr);
        I = 8'(i); J = 8'(j); Data = 8'(d); FrameIn = fr;
        @(posedge Clk); #1;
        Data = 8'd0; FrameIn = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge Clk);
            n++;
        end
        chk("drain_remaining", exp_q.size(), 0);
        exp_q.delete();
        #1;
    endtask

    // Single compare process: every handshake against the model, every stall for stability.
    bit    stall_q = 1'b0;
    beat_t st;
    always @(negedge Clk) begin
        beat_t cur, e;
        if (Reset) begin
            stall_q = 1'b0;
        end else begin
            cur.theta = int'(vif.VoteTheta);
            cur.rho   = int'($signed(vif.VoteRho));
            cur.frame = vif.VoteFrame;
            if (stall_q) begin
                chk("hold_valid", vif.VoteValid, 1);
                chk("hold_theta", cur.theta, st.theta);
                chk("hold_rho", cur.rho, st.rho);
                chk("hold_frame", cur.frame, st.frame);
            end
            if (vif.VoteValid && vif.VoteReady) begin
                $display("beat theta=%0d rho=%0d frame=%0d", cur.theta, cur.rho, cur.frame);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_theta", cur.theta, e.theta);
                    chk("beat_rho", cur.rho, e.rho);
                    chk("beat_frame", cur.frame, e.frame);
                end
                log_q.push_back(cur);
            end
            stall_q = vif.VoteValid && !vif.VoteReady;
            st      = cur;
        end
    end

    initial begin
        int nframe;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_valid", vif.VoteValid, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_overflow", Overflow, 0);
        chk("rst_dropcount", DropCount, 0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        chk("model_rho_10_20_t0", model_rho(10, 20, 0), 10);
        chk("model_rho_10_20_t4", model_rho(10, 20, 4), 21);
        chk("model_rho_10_20_t8", model_rho(10, 20, 8), 20);
        chk("model_cos_t12", mcos(12), -45);
        chk("model_sin_t12", msin(12), 45);
        chk("model_rho_100_0_t12", model_rho(100, 0, 12), -71);

        // Single point: latency, literal rho values, Busy release
        expect_point(10, 20);
        send_px(10, 20, 200, 0);
        @(negedge Clk); chk("lat_busy_after_push", Busy, 1);
        @(negedge Clk); chk("lat_valid_cycle1", vif.VoteValid, 0);
        @(negedge Clk); chk("lat_valid_cycle2", vif.VoteValid, 1);
        drain(200);
        @(negedge Clk); chk("busy_after_sweep", Busy, 0);
        chk("p1_count", log_q.size(), 16);
        if (log_q.size() == 16) begin
            chk("p1_t0_rho", log_q[0].rho, 10);
            chk("p1_t4_rho", log_q[4].rho, 21);
            chk("p1_t8_rho", log_q[8].rho, 20);
            chk("p1_t15_theta", log_q[15].theta, 15);
        end

        // Threshold boundary: 127 rejected, 128 accepted
        @(posedge Clk); #1;
        log_q.delete();
        send_px(50, 50, 127, 0);
        repeat (6) @(posedge Clk); #1;
        chk("thr127_busy", Busy, 0);
        chk("thr127_beats", log_q.size(), 0);
        expect_point(100, 0);
        send_px(100, 0, 128, 0);
        drain(200);
        chk("thr128_count", log_q.size(), 16);
        if (log_q.size() == 16) begin
            chk("p2_t12_theta", log_q[12].theta, 12);
            chk("p2_t12_rho", log_q[12].rho, -71);
        end
        chk("no_drop_yet", Overflow, 0);

        // Overflow: 20 points while stalled, 17 kept, 3 dropped
        ready_level = 1'b0;
        @(posedge Clk); #1;
        log_q.delete();
        for (int p = 0; p < 20; p++) begin
            if (p < 17) expect_point(p * 11 + 3, p * 5 + 2);
            send_px(p * 11 + 3, p * 5 + 2, 200, 0);
        end
        chk("ovf_overflow", Overflow, 1);
        chk("ovf_dropcount", DropCount, 3);
        chk("ovf_valid_stalled", vif.VoteValid, 1);
        chk("ovf_no_beats", log_q.size(), 0);
        repeat (4) @(posedge Clk); #1;
        ready_level = 1'b1;
        drain(1000);
        chk("ovf_total_votes", log_q.size(), 272);
        chk("ovf_dropcount_sticky", DropCount, 3);

        // Random backpressure over 4 points
        log_q.delete();
        rand_mode = 1'b1;
        for (int p = 0; p < 4; p++) begin
            expect_point(255 - p * 40, p * 60 + 7);
            send_px(255 - p * 40, p * 60 + 7, 130 + p, 0);
        end
        drain(3000);
        rand_mode = 1'b0;
        repeat (2) @(posedge Clk); #1;
        chk("rand_total_votes", log_q.size(), 64);

        // Frame marker after 48 votes; second edge while pending absorbed
        log_q.delete();
        expect_point(20, 30); expect_point(40, 50); expect_point(60, 70);
        send_px(20, 30, 140, 0);
        send_px(40, 50, 140, 0);
        send_px(60, 70, 140, 0);
        repeat (5) @(posedge Clk); #1;
        exp_q.push_back('{0, 0, 1'b1});
        send_px(1, 1, 255, 1);
        repeat (4) @(posedge Clk); #1;
        send_px(2, 2, 255, 1);
        drain(500);
        repeat (4) @(posedge Clk); #1;
        nframe = 0;
        foreach (log_q[n]) if (log_q[n].frame) nframe++;
        chk("frame_marker_count", nframe, 1);
        chk("frame_total_beats", log_q.size(), 49);
        if (log_q.size() == 49) begin
            chk("frame_marker_last", log_q[48].frame, 1);
            chk("frame_marker_rho", log_q[48].rho, 0);
        end
        chk("frame_busy_done", Busy, 0);

        // Reset mid-sweep
        log_q.delete();
        expect_point(10, 20);
        send_px(10, 20, 200, 0);
        repeat (5) @(posedge Clk); #1;
        chk("pre_reset_valid", vif.VoteValid, 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_valid", vif.VoteValid, 0);
        chk("arst_rho", int'($signed(vif.VoteRho)), 0);
        chk("arst_theta", vif.VoteTheta, 0);
        chk("arst_busy", Busy, 0);
        chk("arst_overflow", Overflow, 0);
        chk("arst_dropcount", DropCount, 0);
        exp_q.delete();
        log_q.delete();
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b0;
        expect_point(30, 40);
        send_px(30, 40, 200, 0);
        drain(200);
        chk("post_reset_count", log_q.size(), 16);
        if (log_q.size() == 16) begin
            chk("post_reset_t0_theta", log_q[0].theta, 0);
            chk("post_reset_t0_rho", log_q[0].rho, 30);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
